// File: rtl/frame_ecc_pkg.sv
// Shared types and helpers for the frame ECC scanner: result classes,
// FSM state encoding and an elaboration-time ceil(log2) helper.
package frame_ecc_pkg;

    typedef enum logic [1:0] {
        ECC_CLEAN  = 2'b00,
        ECC_SINGLE = 2'b01,
        ECC_DOUBLE = 2'b10,
        ECC_UNCORR = 2'b11
    } ecc_class_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        REPORT = 2'd2
    } state_e;

    // Smallest n with 2**n >= value; only used on constants.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((33'd1 << i) < 33'(value)) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/frame_ecc_word_syn.sv
// Combinational partial syndrome of one frame word: XOR of (p+1) over the set
// bits, where p = word_idx*WORD_W + bit, plus the word's parity.
module frame_ecc_word_syn
    import frame_ecc_pkg::*;
#(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned SYN_W  = 12,
    parameter int unsigned WIDX_W = 6
) (
    input  logic [WORD_W-1:0] din_i,
    input  logic [WIDX_W-1:0] word_idx_i,
    output logic [SYN_W-2:0]  syn_o,
    output logic              par_o
);

    localparam int unsigned S_W = SYN_W - 1;

    always_comb begin
        syn_o = '0;
        for (int unsigned b = 0; b < WORD_W; b++) begin
            if (din_i[b]) begin
                syn_o = syn_o ^ S_W'(32'(word_idx_i) * WORD_W + b + 32'd1);
            end
        end
        par_o = ^din_i;
    end

endmodule

// File: rtl/frame_ecc_scanner.sv
// Frame ECC checker: accumulates a Hamming-plus-parity syndrome over a frame,
// classifies it and reports one registered result per frame.
module frame_ecc_scanner
    import frame_ecc_pkg::*;
#(
    parameter  int unsigned WORD_W      = 32,
    parameter  int unsigned FRAME_WORDS = 41,
    parameter  int unsigned SYN_W       = 12,
    parameter  int unsigned CNT_W       = 8,
    parameter  int unsigned STICKY      = 0,
    localparam int unsigned WIDX_W      = (clog2(FRAME_WORDS) > 0) ? clog2(FRAME_WORDS) : 1,
    localparam int unsigned BIDX_W      = (clog2(WORD_W) > 0) ? clog2(WORD_W) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic [WORD_W-1:0] din_i,
    input  logic              din_valid_i,
    input  logic              din_last_i,
    output logic              din_ready_o,
    output logic              error_o,
    output logic [SYN_W-1:0]  syndrome_o,
    output logic              syndrome_valid_o,
    output logic [1:0]        err_class_o,
    output logic [WIDX_W-1:0] err_word_o,
    output logic [BIDX_W-1:0] err_bit_o,
    output logic              len_err_o,
    output logic [CNT_W-1:0]  err_count_o
);

    localparam int unsigned S_W      = SYN_W - 1;
    localparam int unsigned NBITS    = WORD_W * FRAME_WORDS;
    localparam int unsigned LAST_IDX = FRAME_WORDS - 1;

    state_e            state_q, state_d;
    logic [WIDX_W-1:0] word_cnt_q, word_cnt_d;
    logic [S_W-1:0]    s_acc_q, s_acc_d;
    logic              p_acc_q, p_acc_d;
    logic              ready_q, ready_d;
    logic              sv_q, sv_d;
    logic              err_q, err_d;
    logic [SYN_W-1:0]  syn_q, syn_d;
    ecc_class_e        class_q, class_d;
    logic [WIDX_W-1:0] err_word_q, err_word_d;
    logic [BIDX_W-1:0] err_bit_q, err_bit_d;
    logic              len_err_q, len_err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [S_W-1:0]    w_syn;
    logic              w_par;
    logic              xfer, at_end_idx, frame_end;
    logic [S_W-1:0]    s_fin;
    logic              p_fin, len_fin;
    ecc_class_e        fin_class;
    logic [WIDX_W-1:0] fin_word;
    logic [BIDX_W-1:0] fin_bit;
    logic [CNT_W-1:0]  cnt_inc;

    frame_ecc_word_syn #(
        .WORD_W (WORD_W),
        .SYN_W  (SYN_W),
        .WIDX_W (WIDX_W)
    ) u_word_syn (
        .din_i      (din_i),
        .word_idx_i (word_cnt_q),
        .syn_o      (w_syn),
        .par_o      (w_par)
    );

    assign xfer       = din_valid_i & ready_q;
    assign at_end_idx = (word_cnt_q == WIDX_W'(LAST_IDX));
    assign frame_end  = xfer & (din_last_i | at_end_idx);
    assign s_fin      = s_acc_q ^ w_syn;
    assign p_fin      = p_acc_q ^ w_par;
    assign len_fin    = din_last_i ^ at_end_idx;
    assign cnt_inc    = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

    // Classify the syndrome the frame would have if the current word ends it.
    always_comb begin
        int unsigned addr;
        addr      = 32'(s_fin) - 32'd1;
        fin_class = ECC_UNCORR;
        fin_word  = '0;
        fin_bit   = '0;
        if (len_fin) begin
            fin_class = ECC_UNCORR;
        end else if ((s_fin == '0) && !p_fin) begin
            fin_class = ECC_CLEAN;
        end else if ((s_fin != '0) && p_fin && (addr < NBITS)) begin
            fin_class = ECC_SINGLE;
            fin_word  = WIDX_W'(addr / WORD_W);
            fin_bit   = BIDX_W'(addr % WORD_W);
        end else if ((s_fin != '0) && !p_fin) begin
            fin_class = ECC_DOUBLE;
        end
    end

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        s_acc_d    = s_acc_q;
        p_acc_d    = p_acc_q;
        ready_d    = ready_q;
        sv_d       = 1'b0;
        err_d      = (STICKY != 0) ? err_q : 1'b0;
        syn_d      = syn_q;
        class_d    = class_q;
        err_word_d = err_word_q;
        err_bit_d  = err_bit_q;
        len_err_d  = len_err_q;
        cnt_d      = cnt_q;

        if (clr_i) begin
            cnt_d = '0;
            if (STICKY != 0) begin
                err_d = 1'b0;
            end
        end

        case (state_q)
            IDLE, ACCUM: begin
                if (frame_end) begin
                    state_d    = REPORT;
                    ready_d    = 1'b0;
                    sv_d       = 1'b1;
                    syn_d      = {p_fin, s_fin};
                    class_d    = fin_class;
                    err_word_d = fin_word;
                    err_bit_d  = fin_bit;
                    len_err_d  = len_fin;
                    word_cnt_d = '0;
                    s_acc_d    = '0;
                    p_acc_d    = 1'b0;
                    if (fin_class != ECC_CLEAN) begin
                        err_d = 1'b1;
                        cnt_d = clr_i ? CNT_W'(1) : cnt_inc;
                    end
                end else if (xfer) begin
                    state_d    = ACCUM;
                    word_cnt_d = word_cnt_q + WIDX_W'(1);
                    s_acc_d    = s_fin;
                    p_acc_d    = p_fin;
                end
            end
            REPORT: begin
                state_d = IDLE;
                ready_d = 1'b1;
                // A clear landing on the reported cycle must not erase that report.
                if (clr_i && (class_q != ECC_CLEAN)) begin
                    cnt_d = CNT_W'(1);
                    if (STICKY != 0) begin
                        err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            word_cnt_q <= '0;
            s_acc_q    <= '0;
            p_acc_q    <= 1'b0;
            ready_q    <= 1'b1;
            sv_q       <= 1'b0;
            err_q      <= 1'b0;
            syn_q      <= '0;
            class_q    <= ECC_CLEAN;
            err_word_q <= '0;
            err_bit_q  <= '0;
            len_err_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            s_acc_q    <= s_acc_d;
            p_acc_q    <= p_acc_d;
            ready_q    <= ready_d;
            sv_q       <= sv_d;
            err_q      <= err_d;
            syn_q      <= syn_d;
            class_q    <= class_d;
            err_word_q <= err_word_d;
            err_bit_q  <= err_bit_d;
            len_err_q  <= len_err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign din_ready_o      = ready_q;
    assign error_o          = err_q;
    assign syndrome_o       = syn_q;
    assign syndrome_valid_o = sv_q;
    assign err_class_o      = class_q;
    assign err_word_o       = err_word_q;
    assign err_bit_o        = err_bit_q;
    assign len_err_o        = len_err_q;
    assign err_count_o      = cnt_q;

endmodule

// File: tb/tb_frame_ecc_scanner.sv
// Bench for frame_ecc_scanner: a default instance and a sticky/2-bit-counter
// instance share one stimulus stream and are checked against a frame model.
module tb_frame_ecc_scanner;

    localparam int WORD_W = 32;
    localparam int FW     = 41;
    localparam int NBITS  = WORD_W * FW;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic [31:0] din;
    logic        din_valid;
    logic        din_last;

    logic        rdy0, err0, sv0, len0;
    logic [11:0] syn0;
    logic [1:0]  cls0;
    logic [5:0]  wd0;
    logic [4:0]  bt0;
    logic [7:0]  cnt0;

    logic        rdy1, err1, sv1, len1;
    logic [11:0] syn1;
    logic [1:0]  cls1;
    logic [5:0]  wd1;
    logic [4:0]  bt1;
    logic [1:0]  cnt1;

    int checks;
    int failures;
    logic [WORD_W-1:0] frame [FW];
    int exp_cnt0;
    int exp_cnt1;
    int exp_err1;

    frame_ecc_scanner #(
        .WORD_W(32), .FRAME_WORDS(41), .SYN_W(12), .CNT_W(8), .STICKY(0)
    ) u0 (
        .clk(clk), .rst_n(rst_n), .clr_i(clr), .din_i(din),
        .din_valid_i(din_valid), .din_last_i(din_last), .din_ready_o(rdy0),
        .error_o(err0), .syndrome_o(syn0), .syndrome_valid_o(sv0),
        .err_class_o(cls0), .err_word_o(wd0), .err_bit_o(bt0),
        .len_err_o(len0), .err_count_o(cnt0)
    );

    frame_ecc_scanner #(
        .WORD_W(32), .FRAME_WORDS(41), .SYN_W(12), .CNT_W(2), .STICKY(1)
    ) u1 (
        .clk(clk), .rst_n(rst_n), .clr_i(clr), .din_i(din),
        .din_valid_i(din_valid), .din_last_i(din_last), .din_ready_o(rdy1),
        .error_o(err1), .syndrome_o(syn1), .syndrome_valid_o(sv1),
        .err_class_o(cls1), .err_word_o(wd1), .err_bit_o(bt1),
        .len_err_o(len1), .err_count_o(cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input int expv);
        checks++;
        assert (obs === 32'(expv)) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Spec-level reference: syndrome is the XOR of (p+1) mod 2^11 over set bits.
    task automatic model(input int n, input bit last_flag, output int syn,
                         output int cls, output int wd, output int bt, output int len);
        int s;
        int p;
        int a;
        s = 0;
        p = 0;
        for (int pos = 0; pos < n * WORD_W; pos++) begin
            if (frame[pos / WORD_W][pos % WORD_W]) begin
                s = s ^ ((pos + 1) % 2048);
                p = p ^ 1;
            end
        end
        syn = p * 2048 + s;
        len = (last_flag != (n == FW)) ? 1 : 0;
        wd  = 0;
        bt  = 0;
        a   = s - 1;
        if (len == 1)                            cls = 3;
        else if (s == 0 && p == 0)               cls = 0;
        else if (s != 0 && p == 1 && a < NBITS) begin
            cls = 1;
            wd  = a / WORD_W;
            bt  = a % WORD_W;
        end
        else if (s != 0 && p == 0)               cls = 2;
        else                                     cls = 3;
    endtask

    // Drives n words at negedges with random idle gaps in [gmin,gmax].
    task automatic send_frame(input int n, input bit last_flag, input int gmin,
                              input int gmax, input bit clr_last);
        for (int i = 0; i < n; i++) begin
            int gap;
            int w;
            gap = (gmax > 0) ? int'($urandom_range(gmax, gmin)) : 0;
            for (int g = 0; g < gap; g++) begin
                din_valid = 1'b0;
                din       = $urandom;
                din_last  = 1'($urandom_range(1, 0));
                @(negedge clk);
                chk("gap_no_sv", 32'(sv0), 0);
            end
            w = 0;
            while (!rdy0 && w < 8) begin
                @(negedge clk);
                w++;
            end
            if (w == 8) chk("ready_timeout", 32'(rdy0), 1);
            din_valid = 1'b1;
            din       = frame[i];
            din_last  = last_flag && (i == n - 1);
            clr       = clr_last && (i == n - 1);
            @(negedge clk);
        end
        din_valid = 1'b0;
        din_last  = 1'b0;
        clr       = 1'b0;
    endtask

    task automatic check_report(input string tag, input int n, input bit last_flag,
                                input bit clr_used);
        int syn, cls, wd, bt, len;
        model(n, last_flag, syn, cls, wd, bt, len);
        if (clr_used) begin
            exp_cnt0 = 0;
            exp_cnt1 = 0;
            exp_err1 = 0;
        end
        if (cls != 0) begin
            exp_cnt0 = (exp_cnt0 < 255) ? exp_cnt0 + 1 : 255;
            exp_cnt1 = (exp_cnt1 < 3) ? exp_cnt1 + 1 : 3;
            exp_err1 = 1;
        end
        chk({tag, ".sv0"},   32'(sv0),  1);
        chk({tag, ".rdy0"},  32'(rdy0), 0);
        chk({tag, ".syn0"},  32'(syn0), syn);
        chk({tag, ".cls0"},  32'(cls0), cls);
        chk({tag, ".wd0"},   32'(wd0),  wd);
        chk({tag, ".bt0"},   32'(bt0),  bt);
        chk({tag, ".len0"},  32'(len0), len);
        chk({tag, ".err0"},  32'(err0), (cls != 0) ? 1 : 0);
        chk({tag, ".cnt0"},  32'(cnt0), exp_cnt0);
        chk({tag, ".sv1"},   32'(sv1),  1);
        chk({tag, ".syn1"},  32'(syn1), syn);
        chk({tag, ".cls1"},  32'(cls1), cls);
        chk({tag, ".cnt1"},  32'(cnt1), exp_cnt1);
        chk({tag, ".err1"},  32'(err1), exp_err1);
        @(negedge clk);
        chk({tag, ".sv0_off"},   32'(sv0),  0);
        chk({tag, ".rdy0_back"}, 32'(rdy0), 1);
        chk({tag, ".err0_off"},  32'(err0), 0);
        chk({tag, ".syn0_hold"}, 32'(syn0), syn);
        chk({tag, ".err1_hold"}, 32'(err1), exp_err1);
    endtask

    task automatic clear_frame();
        for (int i = 0; i < FW; i++) frame[i] = '0;
    endtask

    task automatic flip(input int pos);
        frame[pos / WORD_W][pos % WORD_W] = ~frame[pos / WORD_W][pos % WORD_W];
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, ".rdy0"}, 32'(rdy0), 1);
        chk({tag, ".sv0"},  32'(sv0),  0);
        chk({tag, ".err0"}, 32'(err0), 0);
        chk({tag, ".syn0"}, 32'(syn0), 0);
        chk({tag, ".cls0"}, 32'(cls0), 0);
        chk({tag, ".len0"}, 32'(len0), 0);
        chk({tag, ".cnt0"}, 32'(cnt0), 0);
        chk({tag, ".err1"}, 32'(err1), 0);
        chk({tag, ".cnt1"}, 32'(cnt1), 0);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        exp_cnt0  = 0;
        exp_cnt1  = 0;
        exp_err1  = 0;
        rst_n     = 1'b0;
        clr       = 1'b0;
        din       = '0;
        din_valid = 1'b0;
        din_last  = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst_n = 1'b1;
        @(negedge clk);

        clear_frame();
        send_frame(FW, 1'b1, 0, 0, 1'b0);
        check_report("zero", FW, 1'b1, 1'b0);

        clear_frame();
        flip(3 * WORD_W + 5);
        send_frame(FW, 1'b1, 0, 0, 1'b0);
        chk("single.syn_const", 32'(syn0), 32'h866);
        check_report("single", FW, 1'b1, 1'b0);

        clear_frame();
        flip(0);
        flip(1);
        send_frame(FW, 1'b1, 0, 0, 1'b0);
        check_report("double", FW, 1'b1, 1'b0);

        for (int i = 0; i < FW; i++) frame[i] = $urandom;
        send_frame(11, 1'b1, 0, 0, 1'b0);
        check_report("early_last", 11, 1'b1, 1'b0);

        clear_frame();
        send_frame(FW, 1'b1, 0, 0, 1'b0);
        check_report("after_len", FW, 1'b1, 1'b0);

        for (int f = 0; f < 10; f++) begin
            clear_frame();
            if (f % 4 == 3) begin
                for (int i = 0; i < FW; i++) frame[i] = $urandom;
            end else begin
                for (int k = 0; k < int'($urandom_range(3, 0)); k++)
                    flip(int'($urandom_range(NBITS - 1, 0)));
            end
            send_frame(FW, 1'b1, 0, 3, 1'b0);
            check_report($sformatf("rand%0d", f), FW, 1'b1, 1'b0);
        end

        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        exp_cnt0 = 0;
        exp_cnt1 = 0;
        exp_err1 = 0;
        chk("clr1.cnt0", 32'(cnt0), 0);
        chk("clr1.cnt1", 32'(cnt1), 0);
        chk("clr1.err1", 32'(err1), 0);

        for (int f = 0; f < 5; f++) begin
            clear_frame();
            flip(int'($urandom_range(NBITS - 1, 0)));
            send_frame(FW, 1'b1, 0, 2, 1'b0);
            check_report($sformatf("sat%0d", f), FW, 1'b1, 1'b0);
        end
        chk("sat.cnt1", 32'(cnt1), 3);
        chk("sat.err1", 32'(err1), 1);

        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        exp_cnt0 = 0;
        exp_cnt1 = 0;
        exp_err1 = 0;
        chk("clr2.cnt1", 32'(cnt1), 0);
        chk("clr2.err1", 32'(err1), 0);
        chk("clr2.cnt0", 32'(cnt0), 0);

        clear_frame();
        flip(7);
        flip(300);
        send_frame(FW, 1'b1, 0, 0, 1'b1);
        chk("clr_rep.cnt1", 32'(cnt1), 1);
        check_report("clr_rep", FW, 1'b1, 1'b1);

        for (int i = 0; i < FW; i++) frame[i] = $urandom;
        send_frame(21, 1'b0, 0, 1, 1'b0);
        chk("midrst.no_sv", 32'(sv0), 0);
        rst_n = 1'b0;
        #2;
        exp_cnt0 = 0;
        exp_cnt1 = 0;
        exp_err1 = 0;
        check_reset_state("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst.still_no_sv", 32'(sv0), 0);
        clear_frame();
        send_frame(FW, 1'b1, 0, 0, 1'b0);
        check_report("post_rst", FW, 1'b1, 1'b0);

        clear_frame();
        flip(int'($urandom_range(NBITS - 1, 0)));
        flip(int'($urandom_range(NBITS - 1, 0)));
        flip(int'($urandom_range(NBITS - 1, 0)));
        send_frame(FW, 1'b1, 0, 0, 1'b0);
        check_report("nogap", FW, 1'b1, 1'b0);
        send_frame(FW, 1'b1, 1, 7, 1'b0);
        check_report("gaps", FW, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
